// File: rtl/ula_serial_param.sv
// Bit-serial 74181-style ALU: SLICE bits per clock, LSB first, with a registered inter-slice carry.
// Operands and the command are captured on accept; the result and flags register on entry to DONE.
module ula_serial_param #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             a_eq_b,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             p,
  output logic             g,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             cry_q, cry_d;
  logic             gcy_q, gcy_d;
  logic             pacc_q, pacc_d;
  logic             eq_q, eq_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             a_eq_b_q, a_eq_b_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             p_q, p_d;
  logic             g_q, g_d;

  logic [SLICE-1:0] as, bs, x, y, lf, res_s;
  logic [SLICE:0]   sum;
  logic             gc, cmsb, pacc_nx;
  logic [WIDTH-1:0] acc_nx;

  // Current slice is always the low SLICE bits of the shifting operands
  always_comb begin
    as = a_q[SLICE-1:0];
    bs = b_q[SLICE-1:0];
    x  = '0;
    y  = '0;
    lf = '0;
    unique case (s_q[1:0])
      2'b00: x = as;
      2'b01: x = as | bs;
      2'b10: x = as | ~bs;
      2'b11: x = '1;
    endcase
    unique case (s_q[3:2])
      2'b00: y = '0;
      2'b01: y = as & ~bs;
      2'b10: y = as & bs;
      2'b11: y = as;
    endcase
    unique case (s_q)
      4'b0000: lf = ~as;
      4'b0001: lf = ~(as | bs);
      4'b0010: lf = ~as & bs;
      4'b0011: lf = '0;
      4'b0100: lf = ~(as & bs);
      4'b0101: lf = ~bs;
      4'b0110: lf = as ^ bs;
      4'b0111: lf = as & ~bs;
      4'b1000: lf = ~as | bs;
      4'b1001: lf = ~(as ^ bs);
      4'b1010: lf = bs;
      4'b1011: lf = as & bs;
      4'b1100: lf = '1;
      4'b1101: lf = as | ~bs;
      4'b1110: lf = as | bs;
      4'b1111: lf = as;
    endcase
    sum     = {1'b0, x} + {1'b0, y} + (SLICE+1)'(cry_q);
    gc      = 1'(({1'b0, x} + {1'b0, y} + (SLICE+1)'(gcy_q)) >> SLICE);
    cmsb    = sum[SLICE-1] ^ x[SLICE-1] ^ y[SLICE-1];
    pacc_nx = pacc_q & (&(x | y));
    res_s   = m_q ? lf : sum[SLICE-1:0];
    acc_nx  = WIDTH'({res_s, acc_q} >> SLICE);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    cry_d    = cry_q;
    gcy_d    = gcy_q;
    pacc_d   = pacc_q;
    eq_d     = eq_q;
    acc_d    = acc_q;
    f_d      = f_q;
    a_eq_b_d = a_eq_b_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    p_d      = p_q;
    g_d      = g_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          state_d = RUN;
          idx_d   = '0;
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          cry_d   = c_in;
          gcy_d   = 1'b0;
          pacc_d  = 1'b1;
          eq_d    = (a == b);
          acc_d   = '0;
        end
        RUN: begin
          a_d    = a_q >> SLICE;
          b_d    = b_q >> SLICE;
          cry_d  = sum[SLICE];
          gcy_d  = gc;
          pacc_d = pacc_nx;
          acc_d  = acc_nx;
          idx_d  = idx_q + IW'(1);
          if (idx_q == LAST) begin
            state_d  = DONE;
            f_d      = acc_nx;
            a_eq_b_d = eq_q;
            c_out_d  = ~m_q & sum[SLICE];
            ovf_d    = ~m_q & (sum[SLICE] ^ cmsb);
            zero_d   = (acc_nx == '0);
            p_d      = ~m_q & pacc_nx;
            g_d      = ~m_q & gc;
          end
        end
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      cry_q    <= 1'b0;
      gcy_q    <= 1'b0;
      pacc_q   <= 1'b0;
      eq_q     <= 1'b0;
      acc_q    <= '0;
      f_q      <= '0;
      a_eq_b_q <= 1'b0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      p_q      <= 1'b0;
      g_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      cry_q    <= cry_d;
      gcy_q    <= gcy_d;
      pacc_q   <= pacc_d;
      eq_q     <= eq_d;
      acc_q    <= acc_d;
      f_q      <= f_d;
      a_eq_b_q <= a_eq_b_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      p_q      <= p_d;
      g_q      <= g_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign f         = f_q;
  assign a_eq_b    = a_eq_b_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign p         = p_q;
  assign g         = g_q;

endmodule

// File: tb/tb_ula_serial_param.sv
// Bench for ula_serial_param: 8/4 directed vectors and 32/8 random ops,
// checked against a whole-word arithmetic model through result queues.
module tb_ula_serial_param;

  typedef struct packed {
    logic [63:0] f;
    logic co, ov, z, eq, p, g;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit rnd_en     = 1'b0;

  logic       in_valid8 = 0, in_ready8, m8 = 0, cin8 = 0, flush8 = 0;
  logic       out_valid8, out_ready8 = 1;
  logic [7:0] a8 = 0, b8 = 0, f8;
  logic [3:0] s8 = 0;
  logic       eq8, co8, ov8, z8, p8, g8, busy8;

  logic        in_valid32 = 0, in_ready32, m32 = 0, cin32 = 0, flush32 = 0;
  logic        out_valid32, out_ready32;
  logic [31:0] a32 = 0, b32 = 0, f32;
  logic [3:0]  s32 = 0;
  logic        eq32, co32, ov32, z32, p32, g32, busy32;

  res_t q8[$];
  res_t q32[$];

  ula_serial_param #(.WIDTH(8), .SLICE(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .s(s8), .m(m8), .c_in(cin8), .flush(flush8),
    .out_valid(out_valid8), .out_ready(out_ready8), .f(f8),
    .a_eq_b(eq8), .c_out(co8), .overflow(ov8), .zero(z8),
    .p(p8), .g(g8), .busy(busy8)
  );

  ula_serial_param #(.WIDTH(32), .SLICE(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .s(s32), .m(m32), .c_in(cin32), .flush(flush32),
    .out_valid(out_valid32), .out_ready(out_ready32), .f(f32),
    .a_eq_b(eq32), .c_out(co32), .overflow(ov32), .zero(z32),
    .p(p32), .g(g32), .busy(busy32)
  );

  function automatic res_t model(input int w, input logic [63:0] a,
                                 input logic [63:0] b, input logic [3:0] s,
                                 input logic m, input logic cin);
    res_t r;
    logic [63:0] mask, x, y, sum, sum0, l;
    mask = (64'd1 << w) - 64'd1;
    a = a & mask;
    b = b & mask;
    r = '0;
    x = '0;
    y = '0;
    l = '0;
    r.eq = (a == b);
    if (m) begin
      case (s)
        4'd0:  l = ~a;
        4'd1:  l = ~(a | b);
        4'd2:  l = ~a & b;
        4'd3:  l = '0;
        4'd4:  l = ~(a & b);
        4'd5:  l = ~b;
        4'd6:  l = a ^ b;
        4'd7:  l = a & ~b;
        4'd8:  l = ~a | b;
        4'd9:  l = ~(a ^ b);
        4'd10: l = b;
        4'd11: l = a & b;
        4'd12: l = '1;
        4'd13: l = a | ~b;
        4'd14: l = a | b;
        default: l = a;
      endcase
      r.f = l & mask;
    end else begin
      case (s[1:0])
        2'd0: x = a;
        2'd1: x = a | b;
        2'd2: x = a | ~b;
        default: x = '1;
      endcase
      case (s[3:2])
        2'd0: y = '0;
        2'd1: y = a & ~b;
        2'd2: y = a & b;
        default: y = a;
      endcase
      x = x & mask;
      y = y & mask;
      sum  = x + y + {63'd0, cin};
      sum0 = x + y;
      r.f  = sum & mask;
      r.co = sum[w];
      r.ov = (x[w-1] == y[w-1]) && (r.f[w-1] != x[w-1]);
      r.p  = ((x | y) & mask) == mask;
      r.g  = sum0[w];
    end
    r.z = (r.f == 64'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  res_t got8, got32;
  assign got8  = {56'd0, f8, co8, ov8, z8, eq8, p8, g8};
  assign got32 = {32'd0, f32, co32, ov32, z32, eq32, p32, g32};

  always @(negedge clk) begin
    if (!rst && out_valid8) begin
      if (q8.size() == 0)
        chk("dut8 spurious out_valid", 128'(out_valid8), 128'(0));
      else begin
        chk("dut8 result", 128'(got8), 128'(q8[0]));
        if (out_ready8) void'(q8.pop_front());
      end
    end
    if (!rst && out_valid32) begin
      if (q32.size() == 0)
        chk("dut32 spurious out_valid", 128'(out_valid32), 128'(0));
      else begin
        chk("dut32 result", 128'(got32), 128'(q32[0]));
        if (out_ready32) void'(q32.pop_front());
      end
    end
  end

  initial begin
    out_ready32 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready32 = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic start8(input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] s, input logic m, input logic cin);
    int k = 0;
    while (!in_ready8 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("dut8 ready before accept", 128'(in_ready8), 128'(1));
    a8 = a;
    b8 = b;
    s8 = s;
    m8 = m;
    cin8 = cin;
    in_valid8 = 1'b1;
    q8.push_back(model(8, 64'(a), 64'(b), s, m, cin));
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic op8(input string name, input logic [7:0] a,
                     input logic [7:0] b, input logic [3:0] s, input logic m,
                     input logic cin, input logic [7:0] ef, input logic eco,
                     input logic eov, input logic ez, input logic eeq);
    int n;
    res_t r;
    r = model(8, 64'(a), 64'(b), s, m, cin);
    chk({name, " model"}, 128'({r.f, r.co, r.ov, r.z, r.eq}),
        128'({56'd0, ef, eco, eov, ez, eeq}));
    start8(a, b, s, m, cin);
    wait_done8(n);
    chk({name, " latency"}, 128'(n), 128'(2));
    chk({name, " dut"}, 128'({f8, co8, ov8, z8, eq8}),
        128'({ef, eco, eov, ez, eeq}));
    @(posedge clk);
    #1;
    chk({name, " back to idle"}, 128'({in_ready8, busy8}), 128'(2'b10));
  endtask

  initial begin
    int n;
    int k;
    logic [12:0] saved;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    chk("reset dut8", 128'({in_ready8, out_valid8, busy8, f8, eq8, co8, ov8, z8, p8, g8}),
        128'({3'b100, 8'h00, 6'b0}));
    chk("reset dut32", 128'({in_ready32, out_valid32, busy32, f32, eq32, co32, ov32, z32, p32, g32}),
        128'({3'b100, 32'h0, 6'b0}));
    rst = 1'b0;
    @(posedge clk);
    #1;

    op8("add_ovf",      8'h7F, 8'h01, 4'b1001, 0, 0, 8'h80, 0, 1, 0, 0);
    op8("add_wrap",     8'hFF, 8'h01, 4'b1001, 0, 0, 8'h00, 1, 0, 1, 0);
    op8("add_wrap_cin", 8'hFF, 8'h01, 4'b1001, 0, 1, 8'h01, 1, 0, 0, 0);
    op8("sub_eq",       8'h05, 8'h05, 4'b0110, 0, 1, 8'h00, 1, 0, 1, 1);
    op8("sub_eq_nocin", 8'h05, 8'h05, 4'b0110, 0, 0, 8'hFF, 0, 0, 0, 1);
    op8("xor",          8'hA5, 8'h0F, 4'b0110, 1, 0, 8'hAA, 0, 0, 0, 0);
    op8("logic_zero",   8'hA5, 8'h0F, 4'b0011, 1, 0, 8'h00, 0, 0, 1, 0);
    op8("logic_and_ci", 8'hA5, 8'h0F, 4'b1011, 1, 1, 8'h05, 0, 0, 0, 0);
    op8("dec",          8'h10, 8'h33, 4'b1111, 0, 0, 8'h0F, 1, 0, 0, 0);
    op8("inc_ovf",      8'h7F, 8'h00, 4'b0000, 0, 1, 8'h80, 0, 1, 0, 0);

    // Back-pressure: result must hold while out_ready is low
    out_ready8 = 1'b0;
    start8(8'h7F, 8'h01, 4'b1001, 0, 0);
    wait_done8(n);
    chk("hold latency", 128'(n), 128'(2));
    saved = {f8, co8, ov8, z8, eq8, g8};
    chk("hold first", 128'(saved), 128'({8'h80, 5'b01000}));
    for (int i = 0; i < 5; i++) begin
      in_valid8 = 1'b1;
      a8 = 8'h12;
      b8 = 8'h34;
      @(posedge clk);
      #1;
      chk("hold stable", 128'({out_valid8, in_ready8, f8, co8, ov8, z8, eq8, g8}),
          128'({2'b10, saved}));
    end
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    chk("release no accept", 128'({in_ready8, out_valid8, busy8}), 128'(3'b100));
    in_valid8 = 1'b0;
    @(posedge clk);
    #1;

    // Flush beats accept in IDLE
    in_valid8 = 1'b1;
    flush8 = 1'b1;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    flush8 = 1'b0;
    chk("flush beats accept", 128'(busy8), 128'(0));

    // Flush at RUN idx=1
    start8(8'h33, 8'h44, 4'b1001, 0, 0);
    @(posedge clk);
    #1;
    flush8 = 1'b1;
    @(posedge clk);
    #1;
    flush8 = 1'b0;
    chk("flush to idle", 128'({in_ready8, out_valid8, busy8}), 128'(3'b100));
    chk("flush keeps f", 128'({f8, co8, ov8, z8, eq8, g8}), 128'(saved));
    q8.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("flush no output", 128'({out_valid8, busy8}), 128'(0));

    // Reset mid-RUN
    start8(8'hFF, 8'hFF, 4'b1001, 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q8.delete();
    chk("rst mid run", 128'({in_ready8, out_valid8, busy8, f8, eq8, co8, ov8, z8, p8, g8}),
        128'({3'b100, 8'h00, 6'b0}));
    repeat (4) @(posedge clk);
    #1;
    chk("rst no output", 128'({out_valid8, busy8}), 128'(0));

    // WIDTH=32 SLICE=8 random traffic with random back-pressure
    rnd_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      k = 0;
      while (!in_ready32 && k < 100) begin
        @(posedge clk);
        #1;
        k++;
      end
      if (!in_ready32)
        chk("dut32 ready timeout", 128'(in_ready32), 128'(1));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = ra;
      a32 = ra;
      b32 = rb;
      s32 = 4'($urandom_range(0, 15));
      m32 = 1'($urandom_range(0, 1));
      cin32 = 1'($urandom_range(0, 1));
      in_valid32 = 1'b1;
      q32.push_back(model(32, 64'(ra), 64'(rb), s32, m32, cin32));
      @(posedge clk);
      #1;
      in_valid32 = 1'b0;
    end
    k = 0;
    while (q32.size() != 0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    rnd_en = 1'b0;
    chk("dut32 drained", 128'(q32.size()), 128'(0));
    chk("dut8 drained", 128'(q8.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
